ifetch: RTL and testbench

Instruction fetch stage, directly upstream of the decode stage. Keeps the program counter and issues one read per cycle to a synchronous instruction memory with one-cycle latency. Returned words go into a 2-entry buffer with their addresses, and the buffer head is presented to decode through a valid/stall handshake. A redirect from the execute stage reloads the PC and discards all in-flight and buffered fetches.

---
 rtl/ifetch_pkg.sv | 6 +
 rtl/ifetch_buf.sv | 31 +++
 rtl/ifetch.sv | 57 +++++
 tb/tb_ifetch.sv | 118 +++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths and reset address for the fetch stage
package ifetch_pkg;
  localparam int WORD = 32;
  localparam int ADDR = 16;
  localparam int RST_PC = 0;
endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: 2-entry shift FIFO whose head register drives decode directly
module ifetch_buf import ifetch_pkg::*; #(
  parameter int W = WORD + ADDR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] tail;
  logic [1:0] slot;
  assign slot = count - {1'b0, pop};
  // head holds its last value when empty; new data lands in the first free slot after a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && count == 2'd2) head <= tail;
      if (push && slot == 2'd0) head <= din;
      if (push && slot == 2'd1) tail <= din;
    end
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: PC, credit-based issue to a 1-cycle imem, and redirect handling
module ifetch import ifetch_pkg::*; #(
  parameter int DW = WORD,
  parameter int AW = ADDR,
  parameter int RESET_PC = RST_PC
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_re_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic [DW-1:0] imem_data_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_addr_i,
  output logic          v_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] origaddr_o,
  input  logic          stall_i
);
  logic [AW-1:0] pc, pend_addr;
  logic inflight, drop, pop, push;
  logic [1:0] count;
  logic [DW+AW-1:0] head;
  assign v_o = count != 2'd0;
  assign pop = v_o & ~stall_i;
  assign push = inflight & ~drop;
  assign imem_re_o = ~rst & ~jump_i & (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign imem_addr_o = pc;
  assign {inst_o, origaddr_o} = head;
  // a redirect reloads the PC and marks any response landing next cycle as stale
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= AW'(RESET_PC);
      pend_addr <= '0;
      inflight <= 1'b0;
      drop <= 1'b0;
    end else begin
      inflight <= imem_re_o;
      drop <= jump_i & inflight;
      if (jump_i) begin
        pc <= jump_addr_i;
      end else if (imem_re_o) begin
        pc <= pc + AW'(1);
        pend_addr <= pc;
      end
    end
  end
  ifetch_buf #(.W(DW + AW)) u_buf (
    .clk(clk),
    .rst(rst),
    .flush(jump_i),
    .push(push),
    .pop(pop),
    .din({imem_data_i, pend_addr}),
    .head(head),
    .count(count)
  );
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed stimulus with a scoreboard queue of expected fetch addresses
module tb_ifetch;
  logic clk = 1'b0;
  logic rst, imem_re_o, jump_i, v_o, stall_i;
  logic [15:0] imem_addr_o, jump_addr_i, origaddr_o;
  logic [31:0] imem_data_i, inst_o;
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk), .rst(rst),
    .imem_re_o(imem_re_o), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .v_o(v_o), .inst_o(inst_o), .origaddr_o(origaddr_o), .stall_i(stall_i)
  );

  always @(posedge clk)
    imem_data_i <= imem_re_o ? 32'h1000_0000 + {16'h0, imem_addr_o} : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_run(input logic [15:0] start, input int n);
    logic [15:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 16'd1;
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] a;
    if (rst === 1'b0 && v_o === 1'b1 && stall_i === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got addr %h expected none", origaddr_o);
      end else begin
        a = exp_q.pop_front();
        chk("out_addr", {16'h0, origaddr_o}, {16'h0, a});
        chk("out_inst", inst_o, 32'h1000_0000 + {16'h0, a});
      end
    end
  end

  initial begin
    rst = 1'b1;
    stall_i = 1'b0;
    jump_i = 1'b0;
    jump_addr_i = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_re", {31'h0, imem_re_o}, 32'h0);
    chk("rst_v", {31'h0, v_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_origaddr", {16'h0, origaddr_o}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr_o}, 32'h0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 48; c++) begin
      rst = (c == 34);
      stall_i = (c >= 6 && c <= 10) || c == 22 || c >= 43;
      jump_i = (c == 16 || c == 22 || c == 27);
      jump_addr_i = c == 16 ? 16'h0100 : c == 22 ? 16'h0200 : 16'hFFFE;
      if (c == 0) push_run(16'h0000, 10);
      if (c == 16) push_run(16'h0100, 3);
      if (c == 22) push_run(16'h0200, 3);
      if (c == 27) push_run(16'hFFFE, 4);
      if (c == 34) push_run(16'h0000, 6);
      @(negedge clk);
      if (c < 2) begin
        chk("first_re", {31'h0, imem_re_o}, 32'h1);
        chk("first_addr", {16'h0, imem_addr_o}, c);
        chk("first_v", {31'h0, v_o}, 32'h0);
      end
      if (c == 2) chk("first_v_high", {31'h0, v_o}, 32'h1);
      if (c >= 6 && c <= 10) begin
        chk("stall_re", {31'h0, imem_re_o}, 32'h0);
        chk("stall_hold_addr", {16'h0, origaddr_o}, 32'h4);
        chk("stall_hold_v", {31'h0, v_o}, 32'h1);
      end
      if (c == 11) begin
        chk("resume_re", {31'h0, imem_re_o}, 32'h1);
        chk("resume_addr", {16'h0, imem_addr_o}, 32'h6);
      end
      if (c == 17 || c == 23) begin
        chk("jump_re", {31'h0, imem_re_o}, 32'h1);
        chk("jump_addr", {16'h0, imem_addr_o}, c == 17 ? 32'h100 : 32'h200);
      end
      if (c == 17 || c == 18 || c == 23 || c == 24 || c == 35 || c == 36)
        chk("bubble_v", {31'h0, v_o}, 32'h0);
      if (c == 19) chk("jump_target_out", {16'h0, origaddr_o}, 32'h100);
      if (c == 32) chk("wrap_out", {16'h0, origaddr_o}, 32'h0);
      if (c == 34) chk("rst_mid_re", {31'h0, imem_re_o}, 32'h0);
      if (c == 35) begin
        chk("post_rst_re", {31'h0, imem_re_o}, 32'h1);
        chk("post_rst_addr", {16'h0, imem_addr_o}, 32'h0);
        chk("post_rst_inst", inst_o, 32'h0);
        chk("post_rst_origaddr", {16'h0, origaddr_o}, 32'h0);
      end
      @(posedge clk);
      #1;
    end
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
